// File: rtl/alu_pkg.sv
// Shared encodings for the streaming add/multiply unit.
`timescale 1ns/1ps
package alu_pkg;

    localparam int W_DEFAULT  = 32;
    localparam int TW_DEFAULT = 4;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_MUL = 1'b1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/alu_booth_mul.sv
// Radix-2 Booth multiplier: one step per clock, W steps per product.
`timescale 1ns/1ps
module alu_booth_mul #(
    parameter int W = 32
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic [W-1:0]   a,
    input  logic [W-1:0]   b,
    output logic           done,
    output logic [2*W-1:0] product
);

    localparam int CW = (W > 1) ? $clog2(W) : 1;

    // pr = {acc[W:0], multiplier[W-1:0], q}; the extra acc bit keeps
    // subtracting the most-negative multiplicand exact.
    logic [W-1:0]   mcand;
    logic [2*W+1:0] pr;
    logic [2*W+1:0] pr_next;
    logic [W:0]     acc_cur;
    logic [W:0]     acc_add;
    logic [CW-1:0]  cnt;
    logic           busy;

    always_comb begin
        acc_cur = pr[2*W+1:W+1];
        acc_add = acc_cur;
        case (pr[1:0])
            2'b01:   acc_add = acc_cur + {mcand[W-1], mcand};
            2'b10:   acc_add = acc_cur - {mcand[W-1], mcand};
            default: acc_add = acc_cur;
        endcase
        pr_next = {acc_add[W], acc_add, pr[W:1]};
    end

    assign done    = busy && (cnt == CW'(W - 1));
    assign product = pr_next[2*W:1];

    always_ff @(posedge clk) begin
        if (rst) begin
            mcand <= '0;
            pr    <= '0;
            cnt   <= '0;
            busy  <= 1'b0;
        end else if (start) begin
            mcand <= a;
            pr    <= {{(W+1){1'b0}}, b, 1'b0};
            cnt   <= '0;
            busy  <= 1'b1;
        end else if (busy) begin
            pr  <= pr_next;
            cnt <= cnt + 1'b1;
            if (done) begin
                busy <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/alu_stream_unit.sv
// Streaming signed add/multiply with valid/ready handshakes and lane tags.
`timescale 1ns/1ps
module alu_stream_unit
    import alu_pkg::*;
#(
    parameter int W  = W_DEFAULT,
    parameter int TW = TW_DEFAULT
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [W-1:0]  in_a,
    input  logic [W-1:0]  in_b,
    input  logic          in_op,
    input  logic [TW-1:0] in_tag,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [W-1:0]  out_lo,
    output logic [W-1:0]  out_hi,
    output logic [TW-1:0] out_tag,
    output state_t        dbg_state
);

    // Handshakes: a beat moves on a rising edge only when valid && ready;
    // in_ready = IDLE and out_valid = DONE, so a result is never overlapped
    // with a new accept and the DONE payload holds until consumed.
    state_t         state;
    logic [2*W-1:0] sum;
    logic [2*W-1:0] product;
    logic           mul_start;
    logic           mul_done;

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign dbg_state = state;

    assign sum       = {{W{in_a[W-1]}}, in_a} + {{W{in_b[W-1]}}, in_b};
    assign mul_start = in_ready && in_valid && (in_op == OP_MUL);

    alu_booth_mul #(.W(W)) u_mul (
        .clk     (clk),
        .rst     (rst),
        .start   (mul_start),
        .a       (in_a),
        .b       (in_b),
        .done    (mul_done),
        .product (product)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            out_lo  <= '0;
            out_hi  <= '0;
            out_tag <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        out_tag <= in_tag;
                        if (in_op == OP_ADD) begin
                            {out_hi, out_lo} <= sum;
                            state            <= DONE;
                        end else begin
                            state <= MUL;
                        end
                    end
                end
                MUL: begin
                    if (mul_done) begin
                        {out_hi, out_lo} <= product;
                        state            <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/alu_stream_unit.md
ALU_STREAM_UNIT -- requirements
Module: alu_stream_unit

Interface
REQ-001 Parameter: W, default 32, operand width in bits.
REQ-002 Parameter: TW, default 4, tag width (lane index 0..15).
REQ-003 Port: clk  input  1  sole clock, all state updates on rising edge.
REQ-004 Port: rst  input  1  reset, synchronous, active-high.
REQ-005 Port: in_valid  input  1  operand beat valid.
REQ-006 Port: in_ready  output  1  unit can accept a beat.
REQ-007 Port: in_a  input  W  signed operand A.
REQ-008 Port: in_b  input  W  signed operand B.
REQ-009 Port: in_op  input  1  0 = add, 1 = multiply.
REQ-010 Port: in_tag  input  TW  lane tag, returned unchanged with the result.
REQ-011 Port: out_valid  output  1  result beat valid.
REQ-012 Port: out_ready  input  1  consumer accepts result.
REQ-013 Port: out_lo  output  W  low half of the 2W-bit signed result.
REQ-014 Port: out_hi  output  W  high half of the 2W-bit signed result.
REQ-015 Port: out_tag  output  TW  tag of the operation that produced the result.

Function
REQ-016 The unit SHALL use states IDLE, MUL, DONE.
REQ-017 in_ready SHALL equal (state == IDLE); out_valid SHALL equal (state == DONE); both SHALL be combinational decodes of the state register.
REQ-018 An input handshake (in_valid && in_ready at a rising edge) SHALL latch in_a, in_b, in_op and in_tag.
REQ-019 For add, the handshake edge SHALL register {out_hi, out_lo} = sext(a) + sext(b), a 2W-bit signed sum with no overflow, and SHALL move to DONE, giving out_valid one cycle after accept.
REQ-020 For multiply, the handshake edge SHALL clear the accumulator and the step counter and SHALL move to MUL.
REQ-021 In MUL, each edge SHALL perform one radix-2 Booth step (examine the multiplier bit pair, add, subtract or hold the multiplicand, then arithmetic-shift right).
REQ-022 After exactly W steps the unit SHALL move to DONE, giving out_valid W cycles after accept; {out_hi, out_lo} SHALL equal the exact 2W-bit signed product.
REQ-023 In DONE, out_lo, out_hi and out_tag SHALL stay stable until an output handshake occurs.
REQ-024 On an output handshake (out_valid && out_ready) the unit SHALL return to IDLE; no input is accepted in that same cycle.
REQ-025 In_* values SHALL be ignored outside IDLE.
REQ-026 In MUL, out_ready SHALL be ignored.
REQ-027 The most-negative operand SHALL be handled exactly, with no saturation.

Reset
REQ-028 While rst is high at a rising edge, state SHALL become IDLE and out_lo, out_hi, out_tag, the accumulator and the counter SHALL become 0.
REQ-029 After that edge in_ready SHALL be 1 and out_valid SHALL be 0.
REQ-030 Reset SHALL have priority over any handshake.
REQ-031 Reset during MUL or DONE SHALL discard the operation silently; no result beat is produced.

Structure
REQ-032 Package alu_pkg SHALL hold the op encoding (OP_ADD = 0, OP_MUL = 1), the state enum and default W and TW.
REQ-033 The Booth datapath (multiplicand register, accumulator/multiplier shift register, step counter) SHALL be a sub-module, alu_booth_mul, with start/done control.
REQ-034 The handshake FSM and add path SHALL stay in alu_stream_unit.

Verification
REQ-035 Add: a = -5, b = 7, tag = 3 -> out_valid 1 cycle after accept; hi = 0x00000000, lo = 0x00000002, tag = 3.
REQ-036 Add overflow: a = b = 0x7FFFFFFF -> hi = 0x00000000, lo = 0xFFFFFFFE.
REQ-037 Multiply: a = -3, b = 5 -> out_valid exactly 32 cycles after accept; hi = 0xFFFFFFFF, lo = 0xFFFFFFF1.
REQ-038 Multiply: a = b = 0x80000000 -> hi = 0x40000000, lo = 0x00000000.
REQ-039 Backpressure: out_ready held low 10 cycles in DONE -> outputs stable, in_ready = 0 throughout; one result beat on release, then in_ready = 1.
REQ-040 Reset at MUL step 10 -> next cycle in_ready = 1, out_valid = 0, outputs 0; a following add of 1 + 1 gives lo = 2.
REQ-041 Randomized: 16 tagged random signed pairs per op, compared against a 64-bit reference model.
